// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM decode stage: opcodes, funct7 values,
// immediate/writeback selects and the packed datapath control bundle.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Immediate format in [2:0]; [3] marks an unsigned compare (SLTIU/BLTU/BGEU).
    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    localparam logic [1:0] WB_MEM   = 2'b00;
    localparam logic [1:0] WB_ALU   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;
    localparam logic [1:0] WB_AUIPC = 2'b11;

    typedef struct packed {
        logic [4:0] alu_signal;
        logic       reg_file_write;
        logic [2:0] main_mem_write;
        logic [3:0] main_mem_read;
        logic [3:0] branch_control;
        logic [3:0] immediate_select;
        logic       op1_sel;
        logic       op2_sel;
        logic [1:0] reg_write_select;
    } ctrl_t;

endpackage

// File: rtl/rv32im_decode_comb.sv
// Pure combinational RV32I(M) decoder: instruction -> control bundle, illegal flag,
// multiply/divide class. M-extension decoded only when RV32M_EXT_EN is defined.
module rv32im_decode_comb
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o,
    output logic        is_mul_o,
    output logic        is_div_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // Register addresses travel separately; the decoder does not look at them.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        is_mul_o  = 1'b0;
        is_div_o  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_o.alu_signal       = 5'b11000;
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.immediate_select = {1'b0, IMM_U};
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_ALU;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.immediate_select = {1'b0, IMM_U};
                ctrl_o.op1_sel          = 1'b1;
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_AUIPC;
            end
            OPC_JAL: begin
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.branch_control   = 4'b1010;
                ctrl_o.immediate_select = {1'b0, IMM_J};
                ctrl_o.op1_sel          = 1'b1;
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_PC4;
            end
            OPC_JALR: begin
                ctrl_o.alu_signal       = {2'b00, funct3};
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.branch_control   = 4'b1010;
                ctrl_o.immediate_select = {1'b0, IMM_I};
                ctrl_o.op1_sel          = 1'b1;
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_PC4;
            end
            OPC_BRANCH: begin
                ctrl_o.alu_signal       = {2'b00, funct3};
                ctrl_o.branch_control   = {1'b1, funct3};
                ctrl_o.immediate_select = {(funct3[2:1] == 2'b11), IMM_B};
                ctrl_o.op2_sel          = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.alu_signal       = {2'b00, funct3};
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.main_mem_read    = {1'b1, funct3};
                ctrl_o.immediate_select = {1'b0, IMM_I};
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_MEM;
            end
            OPC_STORE: begin
                ctrl_o.alu_signal       = {2'b00, funct3};
                ctrl_o.main_mem_write   = {1'b1, funct3[1:0]};
                ctrl_o.immediate_select = {1'b0, IMM_S};
                ctrl_o.op2_sel          = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_o.alu_signal       = {(funct3 == 3'b101) & instr_i[30], 1'b0, funct3};
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.immediate_select = {(funct3 == 3'b011), IMM_I};
                ctrl_o.op2_sel          = 1'b1;
                ctrl_o.reg_write_select = WB_ALU;
            end
            OPC_OP: begin
                ctrl_o.reg_file_write   = 1'b1;
                ctrl_o.immediate_select = {1'b0, IMM_R};
                ctrl_o.reg_write_select = WB_ALU;
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    ctrl_o.alu_signal = {instr_i[30], 1'b0, funct3};
`ifdef RV32M_EXT_EN
                end else if (funct7 == F7_MEXT) begin
                    ctrl_o.alu_signal = {2'b01, funct3};
                    is_mul_o          = ~funct3[2];
                    is_div_o          = funct3[2];
`endif
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
        // Illegal encodings must never enable a write, read or branch downstream.
        if (illegal_o) begin
            ctrl_o = '0;
        end
    end

endmodule

// File: rtl/rv32im_decode_stage.sv
// Registered decode stage, 1-cycle latency; holds its output under OUT_STALL and
// blocks IN_READY while a multi-cycle M op occupies EX (RV32M_EXT_EN enables M).
module rv32im_decode_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        OUT_STALL,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [4:0]  ALU_SIGNAL,
    output logic        REG_FILE_WRITE,
    output logic [2:0]  MAIN_MEM_WRITE,
    output logic [3:0]  MAIN_MEM_READ,
    output logic [3:0]  BRANCH_CONTROL,
    output logic [3:0]  IMMEDIATE_SELECT,
    output logic        OPARAND_1_SELECT,
    output logic        OPARAND_2_SELECT,
    output logic [1:0]  REG_WRITE_SELECT,
    output logic        MULDIV_BUSY,
    output logic        ILLEGAL
);

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_is_mul;
    logic  dec_is_div;

    ctrl_t ctrl_q, ctrl_d;
    logic  valid_q, valid_d;
    logic  illegal_q, illegal_d;
    logic  busy;
    logic  accept;

    rv32im_decode_comb u_decode_comb (
        .instr_i   (INSTRUCTION),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .is_mul_o  (dec_is_mul),
        .is_div_o  (dec_is_div)
    );

    assign IN_READY = ~OUT_STALL & ~busy;
    assign accept   = IN_VALID & IN_READY;

`ifdef RV32M_EXT_EN
    localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A killed M op is abandoned by EX, so FLUSH frees the unit at once.
    always_comb begin
        cnt_d = cnt_q;
        if (FLUSH) begin
            cnt_d = '0;
        end else if (accept && dec_is_mul) begin
            cnt_d = CNT_W'(MUL_LATENCY - 1);
        end else if (accept && dec_is_div) begin
            cnt_d = CNT_W'(DIV_LATENCY - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
`else
    localparam int unsigned unused_latency = MUL_LATENCY + DIV_LATENCY;
    logic unused_mdiv;
    assign unused_mdiv = dec_is_mul | dec_is_div;
    assign busy        = 1'b0;
`endif

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        if (FLUSH) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            ctrl_d    = '0;
        end else if (!OUT_STALL) begin
            if (accept) begin
                valid_d   = 1'b1;
                ctrl_d    = dec_ctrl;
                illegal_d = dec_illegal;
            end else begin
                valid_d   = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign OUT_VALID        = valid_q;
    assign ILLEGAL          = illegal_q;
    assign MULDIV_BUSY      = busy;
    assign ALU_SIGNAL       = ctrl_q.alu_signal;
    assign REG_FILE_WRITE   = ctrl_q.reg_file_write;
    assign MAIN_MEM_WRITE   = ctrl_q.main_mem_write;
    assign MAIN_MEM_READ    = ctrl_q.main_mem_read;
    assign BRANCH_CONTROL   = ctrl_q.branch_control;
    assign IMMEDIATE_SELECT = ctrl_q.immediate_select;
    assign OPARAND_1_SELECT = ctrl_q.op1_sel;
    assign OPARAND_2_SELECT = ctrl_q.op2_sel;
    assign REG_WRITE_SELECT = ctrl_q.reg_write_select;

endmodule

// File: doc/rv32im_decode_stage.md
# rv32im_decode_stage

Registered, parametrised RV32IM decode stage sitting between the IF/ID and ID/EX pipeline registers of the cpu. It decodes one instruction per cycle into the team's datapath control bundle and registers it with a valid/stall/flush handshake. It also sequences multi-cycle M-extension operations, holding off issue until the multiply/divide unit is free, and flags illegal encodings.

## Interface
- MUL_LATENCY, 2: cycles the EX-stage multiplier occupies per MUL/MULH/MULHSU/MULHU (≥1).
- DIV_LATENCY, 33: cycles the EX-stage divider occupies per DIV/DIVU/REM/REMU (≥1).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- INSTRUCTION  in  32  instruction from IF/ID.
- IN_VALID  in  1  INSTRUCTION is valid.
- IN_READY  out  1  stage accepts INSTRUCTION this cycle.
- OUT_STALL  in  1  EX cannot accept the output this cycle.
- FLUSH  in  1  branch/jump redirect; kill the held output.
- OUT_VALID  out  1  registered bundle is valid.
- ALU_SIGNAL  out  5  ALU op: [2:0] funct3 (000 for AUIPC/JAL), [4] SRAI/SRA/SUB/LUI, [3] M-ext or LUI.
- REG_FILE_WRITE  out  1  writeback enable; 0 for store, branch and illegal.
- MAIN_MEM_WRITE  out  3  [2] store, [1:0] funct3[1:0].
- MAIN_MEM_READ  out  4  [3] load, [2:0] funct3.
- BRANCH_CONTROL  out  4  [3] JAL/JALR/branch, [2:0] 010 for jumps, else funct3.
- IMMEDIATE_SELECT  out  4  immediate format and unsigned flag.
- OPARAND_1_SELECT  out  1  1 = PC (AUIPC, JAL, JALR).
- OPARAND_2_SELECT  out  1  1 = immediate (all non-R-type).
- REG_WRITE_SELECT  out  2  00 load data, 01 ALU, 11 AUIPC.
- MULDIV_BUSY  out  1  multi-cycle M op still occupying EX.
- ILLEGAL  out  1  registered instruction is unrecognised.

## Operation
- Combinational decode feeds a single output register; every output except IN_READY is registered.
- Accept = IN_VALID & IN_READY; IN_READY = ~OUT_STALL & ~MULDIV_BUSY.
- Register update priority: RESET > FLUSH > OUT_STALL (hold) > accept (load, OUT_VALID=1) > idle (OUT_VALID=0).
- FLUSH in the same cycle as accept: the instruction is discarded, OUT_VALID=0 next cycle.
- Busy counter, width $clog2(DIV_LATENCY+1): on accept of a MUL-class op it loads MUL_LATENCY-1; on a DIV/REM op it loads DIV_LATENCY-1. Otherwise it decrements while nonzero. MULDIV_BUSY = (counter != 0). A latency of 1 never asserts busy.
- FLUSH clears the counter to 0 (the killed M op is abandoned by EX).
- Illegal: opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}, or OP with funct7 ∉ {0000000, 0100000, 0000001}. Output is ILLEGAL=1, OUT_VALID=1, all write/read/branch enables 0.
- While OUT_STALL is high with OUT_VALID=1, the held bundle stays bit-stable.

## Timing
- Decode latency 1 cycle: accept at edge n, bundle valid after edge n.
- Back-to-back: one instruction per cycle when not stalled or busy.
- After a DIV accept at edge n, IN_READY is low for cycles n+1 … n+DIV_LATENCY-1 and high again from cycle n+DIV_LATENCY.
- Reset values: OUT_VALID 0, ILLEGAL 0, MULDIV_BUSY 0, REG_FILE_WRITE 0, MAIN_MEM_WRITE 000, MAIN_MEM_READ 0000, BRANCH_CONTROL 0000, all other bundle fields 0. IN_READY is 1 in the first cycle after reset if OUT_STALL=0.
- Reset mid-DIV: counter cleared, the next cycle accepts.

## Configuration
- RV32M_EXT_EN defined: M-extension decoded; ALU_SIGNAL[3] set for funct7=0000001; busy sequencing active.
- Undefined: funct7=0000001 under OP is ILLEGAL; the counter, MUL_LATENCY and DIV_LATENCY logic are removed; MULDIV_BUSY tied 0.

## Structure
- Package rv32_ctrl_pkg: opcode localparams, funct7 constants, immediate-select encodings, REG_WRITE_SELECT encodings, and the packed control-bundle typedef.
- Sub-module rv32im_decode_comb: pure combinational INSTRUCTION → bundle + illegal + is_mul/is_div. The stage wraps it with the register, handshake and counter.

## Test plan
- After reset, ADDI x1,x0,5 (0x00500093) with IN_VALID=1 → next cycle OUT_VALID=1, REG_FILE_WRITE=1, OPARAND_2_SELECT=1, ALU_SIGNAL=00000, REG_WRITE_SELECT=01.
- SW (0x0020A023) → MAIN_MEM_WRITE=110, REG_FILE_WRITE=0; BEQ (0x00000063) → BRANCH_CONTROL=1000, REG_FILE_WRITE=0.
- DIV (0x0220C0B3) with DIV_LATENCY=33, IN_VALID held high → IN_READY low for exactly 32 cycles, next instruction accepted on the 33rd.
- OUT_STALL high for 3 cycles with a valid LW held → bundle unchanged, IN_READY=0; release → next instruction loads.
- FLUSH during DIV busy → MULDIV_BUSY=0 and OUT_VALID=0 next cycle; accept resumes immediately.
- Opcode 0x7F, and MUL with RV32M_EXT_EN undefined → ILLEGAL=1, OUT_VALID=1, all enables 0.
